qspi_ram_responder: RTL and testbench
=====================================

Name: qspi_ram_responder

Overview:
- Device-side QSPI memory responder: the far end of the tinyQV QSPI initiator. It answers quad read (0x0B) and quad write (0x02) commands from an internal byte array.
- Used as a synthesizable RAM A/B stand-in for FPGA bring-up and system-level simulation.
- Oversampled design: all QSPI pins are sampled in the `clk` domain. No logic runs on the QSPI clock.

Parameters:
- ADDR_BITS, 10, byte-address width; memory depth = 2^ADDR_BITS bytes.
- DUMMY_CYCLES, 6, number of QSPI clock rising edges between the last address nibble and the first read data nibble.
- SYNC_STAGES, 2, synchronizer depth on qspi_clk, qspi_cs_n and qspi_d_in.

Ports:
- clk  in  1  system clock; must run at ≥4x the qspi_clk frequency.
- rst_n  in  1  asynchronous active-low reset.
- qspi_clk  in  1  QSPI clock from the initiator.
- qspi_cs_n  in  1  chip select, active low.
- qspi_d_in  in  4  QSPI data from the initiator.
- qspi_d_out  out  4  QSPI data to the initiator.
- qspi_d_oe  out  4  output enable, all bits equal, 1 = drive.
- active  out  1  high while a transaction is selected (synchronized cs_n low).
- cmd_err  out  1  one-cycle pulse when an unsupported command byte is received.

Behaviour:
- Reset values:
  - qspi_d_out=0, qspi_d_oe=0, active=0, cmd_err=0.
  - State=IDLE, address and counters cleared.
  - Memory contents are not reset.
- Synchronization and edge detection:
  - All three inputs pass through SYNC_STAGES flops.
  - Rising/falling edges of qspi_clk are detected on the synchronized signal, one flop behind.
  - Data is sampled with the synchronized d_in on the rising-edge detect cycle.
- Bit order: every byte is 2 nibbles, high nibble first. Command and address are also quad (nibble per edge).
- States:
  - IDLE → CMD on synchronized cs_n falling.
  - CMD: 2 rising edges. On the second edge: 0x0B→ADDR(read), 0x02→ADDR(write), anything else → IGNORE with cmd_err pulsed.
  - ADDR: 6 rising edges form a 24-bit address. Bits above ADDR_BITS are discarded (mirroring).
  - After 6 edges: read→DUMMY, write→WRITE. If DUMMY_CYCLES=0, read goes straight to READ.
  - DUMMY: counts DUMMY_CYCLES rising edges, then READ.
  - READ:
    - Drive qspi_d_oe=4'hF from the first falling edge after entry.
    - On each detected falling edge, present the next nibble on qspi_d_out within 1 clk of the detect.
    - The first nibble is mem[addr][7:4], then mem[addr][3:0]; addr then increments.
  - WRITE:
    - Each pair of rising edges assembles a byte and writes mem[addr] on the cycle after the second nibble.
    - addr then increments.
  - IGNORE: no output drive and no writes until cs_n rises.
- Address wraps from 2^ADDR_BITS-1 to 0 in both read and write bursts. There is no burst length limit.
- cs_n high (synchronized) from any state:
  - Next clk: state=IDLE, qspi_d_oe=0, active=0.
  - A partially received write byte (one nibble) is discarded. Completed bytes stay written.
- Edges while cs_n is high are ignored.
- A cs_n fall and a qspi_clk rise in the same synchronized cycle: the CMD state is entered and that edge counts as the first command nibble.
- qspi_d_oe is never asserted outside READ.
- An asynchronous reset mid-transaction aborts it exactly as a cs_n rise does, with reset values applied immediately.
- active follows synchronized cs_n low with no extra delay beyond the synchronizer.

Test Plan:
- Write then read:
  - Stimulus: cs low; cmd 0x02; addr 0x000010; data 0xA5,0x3C; cs high. Then cmd 0x0B; addr 0x000010; 6 dummy clocks; 4 data clocks.
  - Required: initiator samples nibbles A,5,3,C. qspi_d_oe=F only during the data phase.
- Wrap-around:
  - Stimulus: write 0x11 at 0x3FF and 0x22 at the next byte; then read 2 bytes from 0x3FF.
  - Required: read returns 0x11,0x22, and mem[0x000]=0x22.
- Bad command:
  - Stimulus: cmd 0x9F, then 8 more clocks.
  - Required: cmd_err pulses once, qspi_d_oe stays 0, memory is unchanged.
- Partial byte abort:
  - Stimulus: write cmd at 0x020 with nibbles 7,8,9; then cs high.
  - Required: mem[0x020]=0x78 and mem[0x021] is unchanged.
- Reset mid-read:
  - Stimulus: pull rst_n low during the data phase.
  - Required: qspi_d_oe=0 and active=0 immediately. A subsequent read of the same address returns the correct data.
- Clock ratio:
  - Stimulus: run qspi_clk at clk/4 with random skew on cs/data.
  - Required: a 64-byte write/read burst compares equal.

Source files
------------

// File: rtl/qspi_ram_responder.sv
`timescale 1ns / 1ps
// qspi_ram_responder: oversampled QSPI device that serves quad read (0x0B) and
// quad write (0x02) commands from an internal byte array.
module qspi_ram_responder #(
    parameter int unsigned ADDR_BITS    = 10,
    parameter int unsigned DUMMY_CYCLES = 6,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       qspi_clk,
    input  logic       qspi_cs_n,
    input  logic [3:0] qspi_d_in,
    output logic [3:0] qspi_d_out,
    output logic [3:0] qspi_d_oe,
    output logic       active,
    output logic       cmd_err
);

    localparam int unsigned DEPTH        = 1 << ADDR_BITS;
    localparam int unsigned CNT_W        = 8;
    localparam int unsigned ADDR_NIBBLES = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_READ,
        S_WRITE,
        S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_pipe;
    logic [SYNC_STAGES-1:0] cs_pipe;
    logic [3:0]             d_pipe [SYNC_STAGES];
    logic                   sclk_prev;
    logic                   sclk_sync;
    logic                   cs_sync;
    logic [3:0]             d_sync;
    logic                   rise;
    logic                   fall;

    logic [7:0]             mem [DEPTH];
    logic [7:0]             rd_byte;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [3:0]             cmd_hi_q, cmd_hi_d;
    logic                   nib_q, nib_d;
    logic [3:0]             wbuf_q, wbuf_d;
    logic                   is_read_q, is_read_d;
    logic                   we_q, we_d;
    logic [ADDR_BITS-1:0]   waddr_q, waddr_d;
    logic [7:0]             wdata_q, wdata_d;
    logic [3:0]             dout_q, dout_d;
    logic [3:0]             oe_q, oe_d;
    logic                   cmd_err_q, cmd_err_d;
    logic                   active_q, active_d;

    // Input synchronizers; cs_n resets to deselected so reset never starts a transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_pipe <= '0;
            cs_pipe   <= '1;
            for (int i = 0; i < int'(SYNC_STAGES); i++) d_pipe[i] <= 4'h0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_pipe[0] <= qspi_clk;
            cs_pipe[0]   <= qspi_cs_n;
            d_pipe[0]    <= qspi_d_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sclk_pipe[i] <= sclk_pipe[i-1];
                cs_pipe[i]   <= cs_pipe[i-1];
                d_pipe[i]    <= d_pipe[i-1];
            end
            sclk_prev <= sclk_pipe[SYNC_STAGES-1];
        end
    end

    assign sclk_sync = sclk_pipe[SYNC_STAGES-1];
    assign cs_sync   = cs_pipe[SYNC_STAGES-1];
    assign d_sync    = d_pipe[SYNC_STAGES-1];
    assign rise      = sclk_sync & ~sclk_prev;
    assign fall      = ~sclk_sync & sclk_prev;

    // Byte array; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_q) mem[waddr_q] <= wdata_q;
    end

    assign rd_byte = mem[addr_q];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            cmd_hi_q  <= 4'h0;
            nib_q     <= 1'b0;
            wbuf_q    <= 4'h0;
            is_read_q <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= 8'h00;
            dout_q    <= 4'h0;
            oe_q      <= 4'h0;
            cmd_err_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            cmd_hi_q  <= cmd_hi_d;
            nib_q     <= nib_d;
            wbuf_q    <= wbuf_d;
            is_read_q <= is_read_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            dout_q    <= dout_d;
            oe_q      <= oe_d;
            cmd_err_q <= cmd_err_d;
            active_q  <= active_d;
        end
    end

    // Next-state and output decode; a deselect aborts from any state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        cmd_hi_d  = cmd_hi_q;
        nib_d     = nib_q;
        wbuf_d    = wbuf_q;
        is_read_d = is_read_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        dout_d    = dout_q;
        oe_d      = 4'h0;
        cmd_err_d = 1'b0;
        active_d  = ~cs_sync;

        if (cs_sync) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            nib_d   = 1'b0;
            dout_d  = 4'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    nib_d   = 1'b0;
                    addr_d  = '0;
                    // An edge coinciding with select is the first command nibble.
                    if (rise) begin
                        cmd_hi_d = d_sync;
                        cnt_d    = CNT_W'(1);
                    end
                end
                S_CMD: begin
                    if (rise) begin
                        if (cnt_q == '0) begin
                            cmd_hi_d = d_sync;
                            cnt_d    = CNT_W'(1);
                        end else begin
                            cnt_d = '0;
                            case ({cmd_hi_q, d_sync})
                                8'h0B: begin
                                    state_d   = S_ADDR;
                                    is_read_d = 1'b1;
                                end
                                8'h02: begin
                                    state_d   = S_ADDR;
                                    is_read_d = 1'b0;
                                end
                                default: begin
                                    state_d   = S_IGNORE;
                                    cmd_err_d = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (rise) begin
                        // Truncation drops address bits above the array size.
                        addr_d = ADDR_BITS'({addr_q, d_sync});
                        if (cnt_q == CNT_W'(ADDR_NIBBLES - 1)) begin
                            cnt_d = '0;
                            nib_d = 1'b0;
                            if (!is_read_q)             state_d = S_WRITE;
                            else if (DUMMY_CYCLES == 0) state_d = S_READ;
                            else                        state_d = S_DUMMY;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_DUMMY: begin
                    if (rise) begin
                        if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                            cnt_d   = '0;
                            state_d = S_READ;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_READ: begin
                    oe_d = (fall || oe_q[0]) ? 4'hF : 4'h0;
                    if (fall) begin
                        if (!nib_q) begin
                            dout_d = rd_byte[7:4];
                            nib_d  = 1'b1;
                        end else begin
                            dout_d = rd_byte[3:0];
                            nib_d  = 1'b0;
                            addr_d = addr_q + ADDR_BITS'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (rise) begin
                        if (!nib_q) begin
                            wbuf_d = d_sync;
                            nib_d  = 1'b1;
                        end else begin
                            we_d    = 1'b1;
                            waddr_d = addr_q;
                            wdata_d = {wbuf_q, d_sync};
                            addr_d  = addr_q + ADDR_BITS'(1);
                            nib_d   = 1'b0;
                        end
                    end
                end
                S_IGNORE: begin
                    state_d = S_IGNORE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign qspi_d_out = dout_q;
    assign qspi_d_oe  = oe_q;
    assign active     = active_q;
    assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_qspi_ram_responder.sv
`timescale 1ns / 1ps
// Bench for qspi_ram_responder: drives an initiator-side QSPI model and checks
// every QSPI clock cycle's drive state through a scoreboard queue.
module tb_qspi_ram_responder;

    localparam int CLK_NS = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       qspi_clk;
    logic       qspi_cs_n;
    logic [3:0] qspi_d_in;
    wire  [3:0] qspi_d_out;
    wire  [3:0] qspi_d_oe;
    wire        active;
    wire        cmd_err;

    qspi_ram_responder #(
        .ADDR_BITS   (10),
        .DUMMY_CYCLES(6),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .qspi_clk  (qspi_clk),
        .qspi_cs_n (qspi_cs_n),
        .qspi_d_in (qspi_d_in),
        .qspi_d_out(qspi_d_out),
        .qspi_d_oe (qspi_d_oe),
        .active    (active),
        .cmd_err   (cmd_err)
    );

    always #(CLK_NS / 2) clk = ~clk;

    typedef struct packed {
        logic       chk_data;
        logic [3:0] data;
        logic [3:0] oe;
        logic [7:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   err_pulses = 0;
    int   hp         = 40;
    int   cur_tag    = 0;
    bit   mon_en     = 1'b0;

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the initiator's view just before each QSPI falling edge.
    initial begin : monitor
        exp_t e;
        wait (mon_en);
        forever begin
            @(negedge qspi_clk);
            if (exp_q.size() == 0) begin
                check4("oe_unscheduled", qspi_d_oe, 4'h0);
            end else begin
                e = exp_q.pop_front();
                check4($sformatf("oe_t%0d", e.tag), qspi_d_oe, e.oe);
                if (e.chk_data)
                    check4($sformatf("data_t%0d", e.tag), qspi_d_out, e.data);
            end
        end
    end

    // Count clk cycles with cmd_err high; a correct pulse contributes exactly one.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && cmd_err === 1'b1) err_pulses++;
    end

    // One QSPI clock cycle: data changes with skew after the previous fall.
    task automatic qcycle(input logic [3:0] nib, input logic chk, input logic [3:0] exp_nib);
        int   s;
        exp_t e;
        e.chk_data = chk;
        e.data     = exp_nib;
        e.oe       = chk ? 4'hF : 4'h0;
        e.tag      = 8'(cur_tag);
        exp_q.push_back(e);
        s = int'($urandom_range(0, 4));
        #(s);
        qspi_d_in = nib;
        #(hp - s);
        qspi_clk = 1'b1;
        #(hp);
        qspi_clk = 1'b0;
    endtask

    task automatic qstart();
        int s;
        @(negedge clk);
        s = int'($urandom_range(0, 3));
        #(1 + s);
        qspi_cs_n = 1'b0;
        #(4 * CLK_NS);
        check4("active_on", {3'b000, active}, 4'h1);
    endtask

    task automatic qstop();
        #(hp);
        qspi_cs_n = 1'b1;
        #(8 * CLK_NS);
        check4("active_off", {3'b000, active}, 4'h0);
        check4("oe_off", qspi_d_oe, 4'h0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        qcycle(b[7:4], 1'b0, 4'h0);
        qcycle(b[3:0], 1'b0, 4'h0);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
        send_byte(cmd);
        for (int i = 0; i < 6; i++) qcycle(addr[23-4*i -: 4], 1'b0, 4'h0);
    endtask

    task automatic read_hdr(input logic [23:0] addr);
        send_hdr(8'h0B, addr);
        repeat (6) qcycle(4'h0, 1'b0, 4'h0);
    endtask

    task automatic read_exp(input logic [7:0] b);
        qcycle(4'h0, 1'b1, b[7:4]);
        qcycle(4'h0, 1'b1, b[3:0]);
    endtask

    task automatic write2(input logic [23:0] addr, input logic [7:0] b0, input logic [7:0] b1);
        qstart();
        send_hdr(8'h02, addr);
        send_byte(b0);
        send_byte(b1);
        qstop();
    endtask

    task automatic read2(input logic [23:0] addr, input logic [7:0] b0, input logic [7:0] b1);
        qstart();
        read_hdr(addr);
        read_exp(b0);
        read_exp(b1);
        qstop();
    endtask

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    initial begin : watchdog
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        summary();
        $finish;
    end

    initial begin : stimulus
        int pre;
        rst_n     = 1'b0;
        qspi_clk  = 1'b0;
        qspi_cs_n = 1'b1;
        qspi_d_in = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check4("rst_dout", qspi_d_out, 4'h0);
        check4("rst_oe", qspi_d_oe, 4'h0);
        check4("rst_active", {3'b000, active}, 4'h0);
        check4("rst_cmd_err", {3'b000, cmd_err}, 4'h0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        mon_en = 1'b1;

        // Write then read back two bytes.
        cur_tag = 1;
        write2(24'h000010, 8'hA5, 8'h3C);
        read2(24'h000010, 8'hA5, 8'h3C);

        // Wrap from the last byte to address zero.
        cur_tag = 2;
        write2(24'h0003FF, 8'h11, 8'h22);
        read2(24'h0003FF, 8'h11, 8'h22);
        qstart();
        read_hdr(24'h000000);
        read_exp(8'h22);
        qstop();

        // Unsupported command: one cmd_err pulse, no drive, no write.
        cur_tag = 3;
        pre = err_pulses;
        qstart();
        send_byte(8'h9F);
        qcycle(4'h0, 1'b0, 4'h0);
        qcycle(4'h0, 1'b0, 4'h0);
        qcycle(4'h0, 1'b0, 4'h0);
        qcycle(4'h0, 1'b0, 4'h0);
        qcycle(4'h1, 1'b0, 4'h0);
        qcycle(4'h0, 1'b0, 4'h0);
        qcycle(4'hE, 1'b0, 4'h0);
        qcycle(4'hE, 1'b0, 4'h0);
        qstop();
        check4("cmd_err_pulses", 4'(err_pulses - pre), 4'h1);
        read2(24'h000010, 8'hA5, 8'h3C);

        // Deselect after one nibble of the second byte.
        cur_tag = 4;
        write2(24'h000021, 8'h5A, 8'hC3);
        qstart();
        send_hdr(8'h02, 24'h000020);
        qcycle(4'h7, 1'b0, 4'h0);
        qcycle(4'h8, 1'b0, 4'h0);
        qcycle(4'h9, 1'b0, 4'h0);
        qstop();
        read2(24'h000020, 8'h78, 8'h5A);

        // Asynchronous reset during the read data phase.
        cur_tag = 5;
        qstart();
        read_hdr(24'h000010);
        qcycle(4'h0, 1'b1, 4'hA);
        #2;
        rst_n = 1'b0;
        #1;
        check4("rst_mid_oe", qspi_d_oe, 4'h0);
        check4("rst_mid_active", {3'b000, active}, 4'h0);
        qspi_cs_n = 1'b1;
        #(5 * CLK_NS);
        rst_n = 1'b1;
        #(8 * CLK_NS);
        read2(24'h000010, 8'hA5, 8'h3C);

        // 64-byte burst with QSPI clock at clk/4.
        cur_tag = 6;
        hp = 2 * CLK_NS;
        qstart();
        send_hdr(8'h02, 24'h000100);
        for (int i = 0; i < 64; i++) send_byte(8'(i * 7 + 3));
        qstop();
        qstart();
        read_hdr(24'h000100);
        for (int i = 0; i < 64; i++) read_exp(8'(i * 7 + 3));
        qstop();
        hp = 40;

        check4("scoreboard_drained", 4'(exp_q.size()), 4'h0);
        summary();
        $finish;
    end

endmodule
